// File: rtl/clahe_cdf_calc.sv
`default_nettype none
// ============================================================================
// Module   : clahe_cdf_calc
// Purpose  : Per-frame CLAHE CDF/LUT generator. For each of TILE_NUM tiles it
//            reads the 256-bin histogram, clips it, redistributes the excess
//            evenly, and writes an 8-bit mapping LUT back over the same tile.
// Revision : 1.0 - initial release
// ============================================================================
module clahe_cdf_calc #(
  parameter int TILE_NUM   = 64,
  parameter int BINS       = 256,
  parameter int NORM_MULT  = 1161,
  parameter int NORM_SHIFT = 16
) (
  input  logic                         pclk,
  input  logic                         rst_n,
  input  logic                         cdf_start,
  input  logic [15:0]                  clip_limit,
  output logic                         cdf_busy,
  output logic                         cdf_done,
  output logic [$clog2(TILE_NUM)-1:0]  cdf_tile_idx,
  output logic [$clog2(BINS)-1:0]      cdf_addr,
  output logic                         cdf_rd_en,
  input  logic [15:0]                  cdf_rd_data,
  output logic                         cdf_wr_en,
  output logic [7:0]                   cdf_wr_data
);

  localparam int TW = $clog2(TILE_NUM);
  localparam int AW = $clog2(BINS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_TAIL   = 3'd2,
    S_REDIST = 3'd3,
    S_WRITE  = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tile_next;
  logic [AW-1:0] addr_next;
  logic          rd_en_next, wr_en_next, busy_next, done_next;

  logic [15:0]   clip_lat;
  logic [23:0]   excess;
  logic [15:0]   redist;
  logic [23:0]   cdf_acc;
  logic [15:0]   hist_buf [BINS];

  // Capture datapath: clip the returning histogram word.
  logic          capture;
  logic [AW-1:0] cap_idx;
  logic [15:0]   clipped;

  // LUT datapath: computed one cycle ahead so the write outputs are registered.
  logic          lut_step;
  logic [AW-1:0] lut_bin;
  logic [15:0]   redist_calc;
  logic [15:0]   redist_use;
  logic [23:0]   acc_base;
  logic [23:0]   acc_next;
  logic [34:0]   product;
  logic [34:0]   scaled;
  logic [7:0]    lut_val;

  // Capture index lags the address by one cycle (1-cycle RAM latency); in TAIL
  // the address is still parked on the last bin, which is the one arriving.
  always_comb begin
    capture = (state == S_READ && cdf_addr != '0) || (state == S_TAIL);
    cap_idx = (state == S_TAIL) ? cdf_addr : cdf_addr - AW'(1);
    clipped = (cdf_rd_data < clip_lat) ? cdf_rd_data : clip_lat;
  end

  // Next LUT value: REDIST seeds bin 0 from a zero accumulator, WRITE prepares bin k+1.
  always_comb begin
    lut_step    = (state == S_REDIST) || (state == S_WRITE && cdf_addr != AW'(BINS - 1));
    redist_calc = 16'(excess >> AW);
    redist_use  = (state == S_REDIST) ? redist_calc : redist;
    acc_base    = (state == S_REDIST) ? 24'd0 : cdf_acc;
    lut_bin     = (state == S_REDIST) ? '0 : cdf_addr + AW'(1);
    acc_next    = acc_base + 24'(hist_buf[lut_bin]) + 24'(redist_use);
    product     = 35'(acc_next) * 35'(NORM_MULT);
    scaled      = product >> NORM_SHIFT;
    lut_val     = (scaled > 35'd255) ? 8'hFF : scaled[7:0];
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next = state;
    tile_next  = cdf_tile_idx;
    addr_next  = cdf_addr;
    rd_en_next = 1'b0;
    wr_en_next = 1'b0;
    busy_next  = cdf_busy;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_next = 1'b0;
        if (cdf_start) begin
          state_next = S_READ;
          tile_next  = '0;
          addr_next  = '0;
          rd_en_next = 1'b1;
          busy_next  = 1'b1;
        end
      end
      S_READ: begin
        if (cdf_addr == AW'(BINS - 1)) begin
          state_next = S_TAIL;
        end else begin
          addr_next  = cdf_addr + AW'(1);
          rd_en_next = 1'b1;
        end
      end
      S_TAIL: state_next = S_REDIST;
      S_REDIST: begin
        state_next = S_WRITE;
        addr_next  = '0;
        wr_en_next = 1'b1;
      end
      S_WRITE: begin
        if (cdf_addr == AW'(BINS - 1)) begin
          state_next = S_NEXT;
        end else begin
          addr_next  = cdf_addr + AW'(1);
          wr_en_next = 1'b1;
        end
      end
      S_NEXT: begin
        if (cdf_tile_idx == TW'(TILE_NUM - 1)) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          state_next = S_READ;
          tile_next  = cdf_tile_idx + TW'(1);
          addr_next  = '0;
          rd_en_next = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cdf_tile_idx <= '0;
      cdf_addr     <= '0;
      cdf_rd_en    <= 1'b0;
      cdf_wr_en    <= 1'b0;
      cdf_busy     <= 1'b0;
      cdf_done     <= 1'b0;
    end else begin
      state        <= state_next;
      cdf_tile_idx <= tile_next;
      cdf_addr     <= addr_next;
      cdf_rd_en    <= rd_en_next;
      cdf_wr_en    <= wr_en_next;
      cdf_busy     <= busy_next;
      cdf_done     <= done_next;
    end
  end

  // Clip latch, excess/redistribution and cumulative accumulators, LUT output.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      clip_lat    <= '0;
      excess      <= '0;
      redist      <= '0;
      cdf_acc     <= '0;
      cdf_wr_data <= '0;
    end else begin
      if (state == S_IDLE && cdf_start) begin
        clip_lat <= clip_limit;
        excess   <= '0;
      end else if (capture) begin
        excess <= excess + 24'(cdf_rd_data - clipped);
      end else if (state == S_NEXT) begin
        excess <= '0;
      end
      if (state == S_REDIST) begin
        redist <= redist_calc;
      end
      if (lut_step) begin
        cdf_acc     <= acc_next;
        cdf_wr_data <= lut_val;
      end
    end
  end

  // Clipped-histogram buffer; contents are don't-care after reset.
  always_ff @(posedge pclk) begin
    if (capture) begin
      hist_buf[cap_idx] <= clipped;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clahe_cdf_calc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clahe_cdf_calc
// Purpose  : Scoreboard bench for clahe_cdf_calc with a 1-cycle-latency RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clahe_cdf_calc;

  localparam int EXP_DONE = 32961;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cdf_start = 1'b0;
  logic [15:0] clip_limit = 16'd0;
  logic        cdf_busy, cdf_done, cdf_rd_en, cdf_wr_en;
  logic [5:0]  cdf_tile_idx;
  logic [7:0]  cdf_addr, cdf_wr_data;
  logic [15:0] cdf_rd_data = 16'd0;

  int checks = 0;
  int failures = 0;
  int scen = 0;

  typedef struct packed {
    logic [5:0] tile;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] lut [64][256];

  clahe_cdf_calc dut (
    .pclk(pclk), .rst_n(rst_n), .cdf_start(cdf_start), .clip_limit(clip_limit),
    .cdf_busy(cdf_busy), .cdf_done(cdf_done), .cdf_tile_idx(cdf_tile_idx),
    .cdf_addr(cdf_addr), .cdf_rd_en(cdf_rd_en), .cdf_rd_data(cdf_rd_data),
    .cdf_wr_en(cdf_wr_en), .cdf_wr_data(cdf_wr_data)
  );

  always #5 pclk = ~pclk;

  // Histogram contents per scenario.
  function automatic int hist(int s, int t, int b);
    int v;
    v = 0;
    case (s)
      0: begin
        if (t == 0) v = 56;
        else if (t == 1 && b == 200) v = 100;
      end
      1: begin
        if (t == 1) v = 56;
        else if (t == 3 && b == 100) v = 14400;
        else if (t == 10) v = b;
      end
      2: begin
        if (t == 7 && b == 0) v = 14400;
        else if (t == 9) v = 56;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  // RAM model: read data valid one cycle after the address.
  always @(posedge pclk) begin
    if (cdf_rd_en) cdf_rd_data <= 16'(hist(scen, int'(cdf_tile_idx), int'(cdf_addr)));
  end

  // Reference model: clip, redistribute, accumulate, scale and saturate.
  task automatic push_expected(input int s, input int clip);
    longint cl [256];
    longint h, ex, red, acc, v;
    for (int t = 0; t < 64; t++) begin
      ex = 0;
      for (int b = 0; b < 256; b++) begin
        h = hist(s, t, b);
        cl[b] = (h < clip) ? h : clip;
        ex += h - cl[b];
      end
      red = ex / 256;
      acc = 0;
      for (int b = 0; b < 256; b++) begin
        acc += cl[b] + red;
        v = (acc * 1161) / 65536;
        if (v > 255) v = 255;
        exp_q.push_back({6'(t), 8'(b), 8'(v)});
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every LUT write is popped against the expected queue.
  wr_t got, exp_e;
  always @(negedge pclk) begin
    if (rst_n && cdf_wr_en) begin
      got = {cdf_tile_idx, cdf_addr, cdf_wr_data};
      lut[cdf_tile_idx][cdf_addr] = cdf_wr_data;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write tile=%0d addr=%0d data=%0d", got.tile, got.addr, got.data);
      end else begin
        exp_e = exp_q.pop_front();
        if (got !== exp_e) begin
          failures++;
          $display("FAIL sb_write actual tile=%0d addr=%0d data=%0d required tile=%0d addr=%0d data=%0d",
                   got.tile, got.addr, got.data, exp_e.tile, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  // Full 64-tile run with start pulses while busy and in DONE, and a clip change mid-run.
  task automatic run_full(input int s, input logic [15:0] clip);
    int rd_cnt, wr_cnt, both, done_cnt, done_cyc, busy_bad;
    rd_cnt = 0; wr_cnt = 0; both = 0; done_cnt = 0; done_cyc = 0; busy_bad = 0;
    scen = s;
    exp_q.delete();
    push_expected(s, int'(clip));
    @(negedge pclk);
    clip_limit = clip;
    cdf_start  = 1'b1;
    for (int n = 1; n <= EXP_DONE + 4; n++) begin
      @(negedge pclk);
      if (cdf_rd_en) rd_cnt++;
      if (cdf_wr_en) wr_cnt++;
      if (cdf_rd_en && cdf_wr_en) both++;
      if (cdf_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (cdf_busy !== (n <= EXP_DONE)) busy_bad++;
      if (n == 1) cdf_start = 1'b0;
      if (n == 2) clip_limit = ~clip;
      if (n == 1000) cdf_start = 1'b1;
      if (n == 1001) cdf_start = 1'b0;
      if (n == EXP_DONE) cdf_start = 1'b1;
      if (n == EXP_DONE + 1) cdf_start = 1'b0;
    end
    chk("done_cycle", done_cyc, EXP_DONE);
    chk("done_pulses", done_cnt, 1);
    chk("read_count", rd_cnt, 64 * 256);
    chk("write_count", wr_cnt, 64 * 256);
    chk("rd_wr_overlap", both, 0);
    chk("busy_window_errors", busy_bad, 0);
    chk("sb_left_over", exp_q.size(), 0);
  endtask

  initial begin
    int found;
    for (int t = 0; t < 64; t++)
      for (int b = 0; b < 256; b++)
        lut[t][b] = 8'hAA;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("reset_outputs", {cdf_busy, cdf_done, cdf_tile_idx, cdf_addr, cdf_rd_en, cdf_wr_en, cdf_wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);

    // clip_limit=0 run, aborted by reset in the middle of tile 5's WRITE
    scen = 0;
    exp_q.delete();
    push_expected(0, 0);
    clip_limit = 16'd0;
    cdf_start  = 1'b1;
    @(negedge pclk);
    cdf_start = 1'b0;
    found = 0;
    for (int n = 0; n < 4000 && found == 0; n++) begin
      @(negedge pclk);
      if (cdf_tile_idx == 6'd5 && cdf_wr_en && cdf_addr == 8'd100) found = 1;
    end
    chk("reach_tile5_write", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {cdf_busy, cdf_done, cdf_tile_idx, cdf_addr, cdf_rd_en, cdf_wr_en, cdf_wr_data}, 0);
    exp_q.delete();
    chk("clip0_t0_lut255", lut[0][255], 253);
    chk("clip0_t0_lut0", lut[0][0], 0);
    chk("clip0_t1_lut255", lut[1][255], 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    repeat (3) @(negedge pclk);
    chk("idle_after_abort", {cdf_busy, cdf_rd_en, cdf_wr_en}, 0);

    // Run with clip 400: plain CDF, zero tile, spike tile
    run_full(1, 16'd400);
    chk("t1_lut0", lut[1][0], 0);
    chk("t1_lut255", lut[1][255], 253);
    chk("t3_lut99", lut[3][99], 95);
    chk("t3_lut100", lut[3][100], 103);
    chk("t3_lut255", lut[3][255], 251);
    chk("t0_zero_lut255", lut[0][255], 0);
    chk("t10_lut50", lut[10][50], 22);
    chk("t10_lut255_sat", lut[10][255], 255);
    repeat (3) @(negedge pclk);
    chk("idle_after_run1", cdf_busy, 0);

    // Run with clip 65535: saturation tile
    run_full(2, 16'd65535);
    chk("t7_lut0_sat", lut[7][0], 255);
    chk("t7_lut255_sat", lut[7][255], 255);
    chk("t9_lut127", lut[9][127], 126);
    chk("t9_lut255", lut[9][255], 253);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clahe_cdf_calc.md
Name: clahe_cdf_calc

Overview:
Per-frame CDF/LUT generator for the 64-tile CLAHE pipeline. After histogram statistics finish, it walks all 64 tiles through the CDF interface of the 64-tile ping-pong RAM. For each tile it reads the 256-bin histogram, clips it and redistributes the excess, then overwrites the same tile with an 8-bit mapping LUT. The mapping stage reads that LUT in the following frame once ping_pong_flag toggles. The upstream statistics block must not drive hist_rd_tile_idx onto the active tile while cdf_busy=1, because its read address has priority in the RAM.

Parameters:
TILE_NUM, 64, number of tiles processed per run; tile index width is 6.
BINS, 256, histogram bins per tile; address width is 8.
NORM_MULT, 1161, LUT scale multiplier; equals round(255*2^16/14400) for 160x90 tiles.
NORM_SHIFT, 16, right shift applied after the NORM_MULT multiply.

Ports:
pclk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cdf_start  in  1  one-cycle start pulse (frame done); ignored while busy
clip_limit  in  16  per-bin clip threshold; sampled on accepted start
cdf_busy  out  1  high from the cycle after start is accepted through the DONE state
cdf_done  out  1  one-cycle pulse when all tiles have been written
cdf_tile_idx  out  6  tile being processed
cdf_addr  out  8  bin address, shared by read and write
cdf_rd_en  out  1  histogram read request
cdf_rd_data  in  16  histogram data, valid 1 cycle after address
cdf_wr_en  out  1  LUT write strobe
cdf_wr_data  out  8  LUT value

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; tile counter, bin counter, excess accumulator and cdf accumulator cleared; local buffer contents don't-care.
- Local storage: 256x16 clipped-histogram buffer, plus registers excess (24b), redist (16b) and cdf_acc (24b).
- State IDLE: on cdf_start=1, latch clip_limit, set tile=0, go to READ. cdf_start is ignored in every other state.
- State READ (256 cycles, bin k=0..255):
  - drive cdf_rd_en=1, cdf_addr=k;
  - for k>=1, capture cdf_rd_data as bin k-1;
  - after k=255, go to TAIL.
- State TAIL (1 cycle): cdf_rd_en=0; cdf_tile_idx held; capture bin 255. The RAM output mux uses the current tile index, so the index must stay stable here.
- Capture rule: clipped = min(h, clip_lat); store clipped in buffer[bin]; excess += h - clipped.
- State REDIST (1 cycle):
  - redist = excess >> 8; the remainder is discarded by design;
  - clear cdf_acc; go to WRITE.
- State WRITE (256 cycles, bin k):
  - cdf_acc_next = cdf_acc + buffer[k] + redist;
  - cdf_wr_en=1, cdf_addr=k;
  - cdf_wr_data = min(255, (cdf_acc_next*NORM_MULT) >> NORM_SHIFT), with a 35-bit product before the shift;
  - cdf_acc <= cdf_acc_next; after k=255, go to NEXT.
- State NEXT (1 cycle): wr_en=0; clear excess. If tile==TILE_NUM-1 go to DONE, else tile+1 and go to READ.
- State DONE (1 cycle): cdf_done=1, then IDLE with busy=0.
- Mutual exclusion: cdf_rd_en and cdf_wr_en are never high in the same cycle.
- Outputs are registered. cdf_addr/cdf_tile_idx keep their last value when idle, except at reset.
- Per-tile cost is 515 cycles. With cycle 1 = first cycle after start is accepted, cdf_done is high in cycle 64*515+1 = 32961.
- Boundary cases:
  - clip_limit=0: every bin clips to 0 and all counts become excess.
  - clip_limit >= every bin: excess=0 and the result is a plain CDF.
  - Accumulators cannot overflow for tiles of at most 2^24-1 pixels.
  - A start coincident with DONE is ignored.
  - Reset mid-tile aborts immediately; partially written LUTs are left as-is.

Test Plan:
- Reset mid-WRITE of tile 5 → all outputs 0 next cycle; a new cdf_start restarts from tile 0; done is still at cycle 32961.
- All histograms 0, clip 400 → every LUT entry 0; exactly 64*256 writes and 64*256 reads; done pulse at cycle 32961 with busy high for cycles 1..32961.
- Every bin=56, clip 1000 → excess 0; LUT[0]=0, LUT[255]=253 (14336*1161>>16).
- Tile 3 bin100=14400, others 0, clip 400 → excess 14000, redist 54; LUT[99]=95, LUT[100]=103, LUT[255]=251.
- Bin0=14400, clip 65535 → LUT[0..255]=255 (saturation of 255.1).
- cdf_start pulsed during busy and again in the DONE cycle → ignored; clip_limit changed mid-run has no effect on the run in progress.
